// File: rtl/vec_add.sv
// vec_add: three-lane signed 32-bit vector adder stage for the fifo_math
// pipeline. It pops one vector from each operand FIFO, forms the lane-wise
// sum (optionally clamped on overflow) and pushes it into an internal
// output FIFO. A small first-word-fall-through FIFO, fifo_array, lives in
// this file as well.

module fifo_array #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 96
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_wr;
  logic             do_rd;

  // Writes into a full FIFO and reads from an empty one are ignored.
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; the head is always visible on dout.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy gates the head.
  always_ff @(posedge clock) begin
    if (do_wr) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

module vec_add #(
  parameter int FIFO_BUFFER_SIZE = 1024,
  parameter bit SATURATE         = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [2:0][31:0] a,
  input  logic            a_empty,
  output logic            a_rd_en,
  input  logic [2:0][31:0] b,
  input  logic            b_empty,
  output logic            b_rd_en,
  output logic [2:0][31:0] out,
  output logic            out_empty,
  input  logic            out_rd_en,
  output logic [15:0]     sat_count
);

  typedef enum logic {
    S_LOAD  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [2:0][32:0] wide_sum;
  logic [2:0][31:0] lane_sum;
  logic [2:0]       lane_clamp;
  logic [2:0][31:0] sum_reg;
  logic             load_fire;
  logic             out_wr_en;
  logic             out_full;
  logic             fifo_reset;

  // Lane arithmetic: 33-bit sign-extended add, clamped when bits 32 and 31 differ.
  always_comb begin
    wide_sum   = '0;
    lane_sum   = '0;
    lane_clamp = '0;
    for (int i = 0; i < 3; i++) begin
      wide_sum[i] = {a[i][31], a[i]} + {b[i][31], b[i]};
      if (SATURATE && (wide_sum[i][32] != wide_sum[i][31])) begin
        lane_clamp[i] = 1'b1;
        lane_sum[i]   = wide_sum[i][32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
        lane_sum[i]   = wide_sum[i][31:0];
      end
    end
  end

  // Handshake decisions; everything is held low while reset is asserted.
  always_comb begin
    next_state = state;
    a_rd_en    = 1'b0;
    b_rd_en    = 1'b0;
    out_wr_en  = 1'b0;
    case (state)
      S_LOAD: begin
        if (reset && !a_empty && !b_empty) begin
          a_rd_en    = 1'b1;
          b_rd_en    = 1'b1;
          next_state = S_WRITE;
        end
      end
      S_WRITE: begin
        if (reset && !out_full) begin
          out_wr_en  = 1'b1;
          next_state = S_LOAD;
        end
      end
      default: next_state = S_LOAD;
    endcase
  end

  assign load_fire = a_rd_en;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_LOAD;
    end else begin
      state <= next_state;
    end
  end

  // Sum register captures the lanes on the pop cycle and holds through stalls.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sum_reg <= '0;
    end else if (load_fire) begin
      sum_reg <= lane_sum;
    end
  end

  // Counts vectors with any clamped lane, sticking at the top value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sat_count <= '0;
    end else if (load_fire && (|lane_clamp) && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end

  assign fifo_reset = ~reset;

  fifo_array #(
    .DEPTH (FIFO_BUFFER_SIZE),
    .WIDTH (96)
  ) u_out_fifo (
    .clock (clock),
    .reset (fifo_reset),
    .wr_en (out_wr_en),
    .din   (sum_reg),
    .full  (out_full),
    .rd_en (out_rd_en),
    .dout  (out),
    .empty (out_empty)
  );

endmodule
